flash_rom_streamer: RTL and testbench

- SPI-flash-to-download-stream source. Reads a ROM image from the W25Q64 boot flash and emits it as the byte stream (DO/WR/ON) that the game loader consumes.
- It is the transmitting end of the download interface whose receiver is the game loader.
- Sits beside the OSD. When running, it owns the flash SPI pins through the top-level mux.

---
 rtl/flash_rom_streamer.sv | 186 ++++++++++++++++++
 tb/tb_flash_rom_streamer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rom_streamer.sv
// Streams a ROM image out of a W25Q64 SPI flash (mode 0 READ) onto the game-loader download bus.
// Define FLASH_FAST_READ_EN to use FAST READ (0x0B) with an 8-clock dummy phase.
module flash_rom_streamer #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 22
) (
  input  logic             I_CLK,
  input  logic             I_RESET_N,
  input  logic             I_START,
  input  logic [23:0]      I_ADDR,
  input  logic [LEN_W-1:0] I_LEN,
  input  logic             I_SPI_MISO,
  output logic             O_SPI_CLK,
  output logic             O_SPI_MOSI,
  output logic             O_SPI_CS_N,
  output logic [7:0]       O_DOWNLOAD_DO,
  output logic             O_DOWNLOAD_WR,
  output logic             O_DOWNLOAD_ON,
  output logic             O_BUSY,
  output logic             O_DONE
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
`ifdef FLASH_FAST_READ_EN
    DUMMY,
`endif
    DATA,
    FINISH
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      tx;
  logic [7:0]       rx;
  logic [LEN_W-1:0] len;
  logic             pend;
  logic             stop;
  logic             sck;
  logic             mosi;
  logic             cs_n;
  logic [7:0]       dout;
  logic             wr;
  logic             on;
  logic             busy;
  logic             done;
  logic             tick;

  // One tick per SCK half-period; the counter restarts when CS_N falls.
  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      len     <= '0;
      pend    <= 1'b0;
      stop    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      dout    <= 8'h00;
      wr      <= 1'b0;
      on      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (I_START) begin
            if (I_LEN != '0) begin
              state   <= CMD;
              len     <= I_LEN;
              tx      <= {CMD_BYTE[6:0], I_ADDR, 1'b0};
              mosi    <= CMD_BYTE[7];
              div_cnt <= '0;
              bit_cnt <= '0;
              sck     <= 1'b0;
              pend    <= 1'b0;
              stop    <= 1'b0;
              cs_n    <= 1'b0;
              on      <= 1'b1;
              busy    <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FINISH: begin
          cs_n  <= 1'b1;
          sck   <= 1'b0;
          mosi  <= 1'b0;
          on    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          // A completed byte is published one clock after its last SCK period ends.
          if (pend) begin
            pend <= 1'b0;
            wr   <= 1'b1;
            dout <= rx;
            len  <= len - 1'b1;
            if (len == LEN_W'(1)) state <= FINISH;
          end
          if (!stop) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
              if (!sck) begin
                sck <= 1'b1;
                if (state == DATA) rx <= {rx[6:0], I_SPI_MISO};
              end else begin
                // Falling edge closes a bit period; MOSI moves while SCK is low.
                sck     <= 1'b0;
                mosi    <= tx[31];
                tx      <= {tx[30:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                case (state)
                  CMD: begin
                    if (bit_cnt == 5'd7) begin
                      state   <= ADDR;
                      bit_cnt <= '0;
                    end
                  end
                  ADDR: begin
                    if (bit_cnt == 5'd23) begin
`ifdef FLASH_FAST_READ_EN
                      state   <= DUMMY;
`else
                      state   <= DATA;
`endif
                      bit_cnt <= '0;
                    end
                  end
`ifdef FLASH_FAST_READ_EN
                  DUMMY: begin
                    if (bit_cnt == 5'd7) begin
                      state   <= DATA;
                      bit_cnt <= '0;
                    end
                  end
`endif
                  DATA: begin
                    if (bit_cnt == 5'd7) begin
                      bit_cnt <= '0;
                      pend    <= 1'b1;
                      if (len == LEN_W'(1)) stop <= 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        end
      endcase
    end
  end

  assign O_SPI_CLK     = sck;
  assign O_SPI_MOSI    = mosi;
  assign O_SPI_CS_N    = cs_n;
  assign O_DOWNLOAD_DO = dout;
  assign O_DOWNLOAD_WR = wr;
  assign O_DOWNLOAD_ON = on;
  assign O_BUSY        = busy;
  assign O_DONE        = done;

endmodule

// File: tb/tb_flash_rom_streamer.sv
// Bench for flash_rom_streamer: SPI flash model with byte[n]=n[7:0] and a stream scoreboard.
module tb_flash_rom_streamer;

`ifdef FLASH_FAST_READ_EN
  localparam int HDR = 40;
`else
  localparam int HDR = 32;
`endif
  localparam int CLK_DIV   = 2;
  localparam int BIT_CLKS  = 2 * CLK_DIV;
  localparam int FIRST_LAT = (HDR + 8) * BIT_CLKS + 1;
  localparam int SPACING   = 8 * BIT_CLKS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [21:0] len = '0;
  logic        miso = 1'b0;
  logic        sck, mosi, cs_n, dl_wr, dl_on, busy, done;
  logic [7:0]  dl_do;

  flash_rom_streamer #(.CLK_DIV(CLK_DIV), .LEN_W(22)) dut (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_START(start), .I_ADDR(addr), .I_LEN(len),
    .I_SPI_MISO(miso), .O_SPI_CLK(sck), .O_SPI_MOSI(mosi), .O_SPI_CS_N(cs_n),
    .O_DOWNLOAD_DO(dl_do), .O_DOWNLOAD_WR(dl_wr), .O_DOWNLOAD_ON(dl_on),
    .O_BUSY(busy), .O_DONE(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Flash model: captures the header bits, then serves byte[a]=a[7:0] from the latched address.
  int          bitn = 0;
  logic [39:0] hdr_bits = '0;
  logic [23:0] fa;
  logic [7:0]  fb;
  int          k;

  always @(negedge cs_n) begin
    bitn = 0;
    hdr_bits = '0;
  end

  always @(posedge sck) begin
    if (!cs_n) begin
      if (bitn < HDR) hdr_bits = {hdr_bits[38:0], mosi};
      bitn = bitn + 1;
    end
  end

  always @(negedge sck) begin
    if (!cs_n && bitn >= HDR) begin
      k = bitn - HDR;
`ifdef FLASH_FAST_READ_EN
      fa = hdr_bits[31:8] + 24'(k / 8);
`else
      fa = hdr_bits[23:0] + 24'(k / 8);
`endif
      fb = fa[7:0];
      miso = fb[7 - (k % 8)];
    end
  end

  // Stream monitor, sampled on the falling clock edge.
  logic [7:0] wr_q[$];
  int         wr_t[$];
  int         done_cnt = 0, done_cyc = 0, cs_fall_cyc = 0, cs_fall_cnt = 0;
  int         on_fall_cyc = 0, on_rise_cnt = 0;
  logic       prev_cs = 1'b1, prev_on = 1'b0;

  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      cs_fall_cyc = cyc;
      cs_fall_cnt = cs_fall_cnt + 1;
    end
    if (!prev_cs && cs_n) begin
      checks = checks + 1;
      if (sck !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL cs_rise_sck: sck=%b required 0", sck);
      end
    end
    if (!prev_on && dl_on) on_rise_cnt = on_rise_cnt + 1;
    if (prev_on && !dl_on) on_fall_cyc = cyc;
    if (dl_wr) begin
      wr_q.push_back(dl_do);
      wr_t.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    prev_cs = cs_n;
    prev_on = dl_on;
  end

  logic [7:0] exp_q[$];

  task automatic build_exp(input logic [23:0] a, input int n);
    logic [23:0] t;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      t = a + 24'(i);
      exp_q.push_back(t[7:0]);
    end
  endtask

  task automatic do_transfer(input logic [23:0] a, input int n);
    int d0;
    int i;
    wr_q.delete();
    wr_t.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    addr = a;
    len = 22'(n);
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (done_cnt == d0 && i < 5000) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL timeout_done: addr=%h len=%0d no DONE within 5000 clocks", a, n);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 8;
    if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b need 0", sck); end
    if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b need 0", mosi); end
    if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b need 1", cs_n); end
    if (dl_do !== 8'h00) begin errors++; $display("FAIL reset_do: got %h need 00", dl_do); end
    if (dl_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b need 0", dl_wr); end
    if (dl_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %b need 0", dl_on); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", done); end
  endtask

  task automatic test_basic;
    logic [39:0] exp_hdr;
    int last;
    int d0;
    d0 = done_cnt;
`ifdef FLASH_FAST_READ_EN
    exp_hdr = 40'h0B00010000;
`else
    exp_hdr = 40'h0003000100;
`endif
    do_transfer(24'h000100, 4);
    build_exp(24'h000100, 4);
    checks++;
    if (hdr_bits !== exp_hdr) begin errors++; $display("FAIL basic_mosi: got %h need %h", hdr_bits, exp_hdr); end
    checks++;
    if (wr_q.size() != 4) begin errors++; $display("FAIL basic_wr_count: got %0d need 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_do[%0d]: got %h need %h", i, wr_q[i], exp_q[i]); end
    end
    for (int i = 1; i < wr_t.size(); i++) begin
      checks++;
      if (wr_t[i] - wr_t[i-1] != SPACING) begin
        errors++; $display("FAIL basic_spacing[%0d]: got %0d need %0d", i, wr_t[i] - wr_t[i-1], SPACING);
      end
    end
    if (wr_t.size() > 0) begin
      last = wr_t[wr_t.size()-1];
      checks += 3;
      if (wr_t[0] - cs_fall_cyc != FIRST_LAT) begin
        errors++; $display("FAIL basic_latency: got %0d need %0d", wr_t[0] - cs_fall_cyc, FIRST_LAT);
      end
      if (done_cyc != last + 1) begin errors++; $display("FAIL basic_done_time: got %0d need %0d", done_cyc, last + 1); end
      if (on_fall_cyc != last + 1) begin errors++; $display("FAIL basic_on_fall: got %0d need %0d", on_fall_cyc, last + 1); end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d need 1", done_cnt - d0); end
  endtask

  task automatic test_len_zero;
    int cs0, on0, d0;
    cs0 = cs_fall_cnt;
    on0 = on_rise_cnt;
    d0 = done_cnt;
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    addr = 24'h123456;
    len = '0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b need 1", done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL len0_done_width: got %b need 0", done); end
    repeat (20) @(negedge clk);
    #1;
    checks += 4;
    if (cs_fall_cnt != cs0) begin errors++; $display("FAIL len0_cs: got %0d falls need 0", cs_fall_cnt - cs0); end
    if (on_rise_cnt != on0) begin errors++; $display("FAIL len0_on: got %0d rises need 0", on_rise_cnt - on0); end
    if (wr_q.size() != 0) begin errors++; $display("FAIL len0_wr: got %0d need 0", wr_q.size()); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL len0_done_count: got %0d need 1", done_cnt - d0); end
  endtask

  task automatic test_wrap;
    do_transfer(24'hFFFFFE, 4);
    build_exp(24'hFFFFFE, 4);
    checks++;
    if (wr_q.size() != 4) begin errors++; $display("FAIL wrap_wr_count: got %0d need 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_do[%0d]: got %h need %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int d0, i;
    logic [23:0] a;
    a = 24'($urandom);
    d0 = done_cnt;
    wr_q.delete();
    wr_t.delete();
    @(negedge clk);
    start = 1'b1;
    addr = a;
    len = 22'd16;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (wr_q.size() < 2 && i < 2000) begin
      @(negedge clk);
      #1;
      i++;
    end
    checks++;
    if (wr_q.size() != 2) begin errors++; $display("FAIL mid_reach_wr2: got %0d need 2", wr_q.size()); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n: got %b need 1", cs_n); end
    if (dl_on !== 1'b0) begin errors++; $display("FAIL mid_on: got %b need 0", dl_on); end
    if (sck !== 1'b0) begin errors++; $display("FAIL mid_sck: got %b need 0", sck); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b need 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    #1;
    checks += 2;
    if (wr_q.size() != 2) begin errors++; $display("FAIL mid_no_more_wr: got %0d need 2", wr_q.size()); end
    if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done: got %0d need 0", done_cnt - d0); end
    a = 24'($urandom);
    do_transfer(a, 3);
    build_exp(a, 3);
    checks++;
    if (wr_q.size() != 3) begin errors++; $display("FAIL mid_restart_count: got %0d need 3", wr_q.size()); end
    for (int j = 0; j < 3 && j < wr_q.size(); j++) begin
      checks++;
      if (wr_q[j] !== exp_q[j]) begin errors++; $display("FAIL mid_restart_do[%0d]: got %h need %h", j, wr_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_back_to_back;
    int d0, i, n;
    logic [23:0] a;
    a = 24'($urandom);
    n = $urandom_range(3, 5);
    d0 = done_cnt;
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    addr = a;
    len = 22'(n);
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(5, 150)) @(negedge clk);
    start = 1'b1;
    addr = a + 24'h5A5A;
    len = 22'd2;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (done_cnt == d0 && i < 5000) begin
      @(negedge clk);
      #1;
      i++;
    end
    repeat (400) @(negedge clk);
    #1;
    build_exp(a, n);
    checks += 2;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_done_count: got %0d need 1", done_cnt - d0); end
    if (wr_q.size() != n) begin errors++; $display("FAIL b2b_wr_count: got %0d need %0d", wr_q.size(), n); end
    for (int j = 0; j < n && j < wr_q.size(); j++) begin
      checks++;
      if (wr_q[j] !== exp_q[j]) begin errors++; $display("FAIL b2b_do[%0d]: got %h need %h", j, wr_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_random;
    logic [23:0] a;
    int n;
    for (int r = 0; r < 4; r++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      do_transfer(a, n);
      build_exp(a, n);
      checks++;
      if (wr_q.size() != n) begin errors++; $display("FAIL rand%0d_count: got %0d need %0d", r, wr_q.size(), n); end
      for (int j = 0; j < n && j < wr_q.size(); j++) begin
        checks++;
        if (wr_q[j] !== exp_q[j]) begin errors++; $display("FAIL rand%0d_do[%0d]: got %h need %h", r, j, wr_q[j], exp_q[j]); end
      end
      if (wr_t.size() > 0) begin
        checks += 2;
        if (wr_t[0] - cs_fall_cyc != FIRST_LAT) begin
          errors++; $display("FAIL rand%0d_latency: got %0d need %0d", r, wr_t[0] - cs_fall_cyc, FIRST_LAT);
        end
        if (done_cyc != wr_t[wr_t.size()-1] + 1) begin
          errors++; $display("FAIL rand%0d_done_time: got %0d need %0d", r, done_cyc, wr_t[wr_t.size()-1] + 1);
        end
      end
    end
  endtask

`ifdef FLASH_FAST_READ_EN
  task automatic test_fast_read;
    do_transfer(24'h000000, 2);
    checks += 3;
    if (hdr_bits !== 40'h0B00000000) begin errors++; $display("FAIL fast_mosi: got %h need 0b00000000", hdr_bits); end
    if (wr_q.size() != 2) begin errors++; $display("FAIL fast_count: got %0d need 2", wr_q.size()); end
    if (wr_t.size() > 0 && wr_t[0] - cs_fall_cyc != 193) begin
      errors++; $display("FAIL fast_latency: got %0d need 193", wr_t[0] - cs_fall_cyc);
    end
    for (int j = 0; j < 2 && j < wr_q.size(); j++) begin
      checks++;
      if (wr_q[j] !== 8'(j)) begin errors++; $display("FAIL fast_do[%0d]: got %h need %h", j, wr_q[j], 8'(j)); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_len_zero;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    test_random;
`ifdef FLASH_FAST_READ_EN
    test_fast_read;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
